// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver (5-9 data bits, optional parity, 1-2 stops) with error flags and a valid/ready output register
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 87,
  parameter int DATA_BITS = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic                 i_Rx_Ready,
  output logic                 o_Rx_Valid,
  output logic [DATA_BITS-1:0] o_Rx_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);
  localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_PARITY = 3'd3, S_STOP = 3'd4, S_WAIT = 3'd5;
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
  logic sync_q, rx_s_q;
  logic [2:0] state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0] idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
  logic perr_q, perr_d, ferr_q, ferr_d, ones_q, ones_d;
  logic valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d, ovr_q, ovr_d;
  logic sample;
  assign sample = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    shift_d = shift_q;
    perr_d = perr_q;
    ferr_d = ferr_q;
    ones_d = ones_q;
    valid_d = valid_q & ~i_Rx_Ready;
    data_d = data_q;
    pe_d = pe_q;
    fe_d = fe_q;
    brk_d = brk_q;
    ovr_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        ones_d = 1'b0;
        state_d = rx_s_q ? S_IDLE : S_START;
      end
      S_START: begin
        cnt_d = (cnt_q == HALF) ? '0 : cnt_q + 16'd1;
        state_d = (cnt_q == HALF) ? (rx_s_q ? S_IDLE : S_DATA) : S_START;
      end
      S_DATA: begin
        cnt_d = sample ? '0 : cnt_q + 16'd1;
        if (sample) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          ones_d = ones_q | rx_s_q;
          idx_d = (idx_q == 4'(DATA_BITS - 1)) ? '0 : idx_q + 4'd1;
          state_d = (idx_q != 4'(DATA_BITS - 1)) ? S_DATA : (PARITY_MODE != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        cnt_d = sample ? '0 : cnt_q + 16'd1;
        if (sample) begin
          perr_d = (PARITY_MODE == 1) ? ~(^shift_q ^ rx_s_q) : (^shift_q ^ rx_s_q);
          ones_d = ones_q | rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = sample ? '0 : cnt_q + 16'd1;
        if (sample) begin
          ferr_d = ferr_q | ~rx_s_q;
          ones_d = ones_q | rx_s_q;
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'(STOP_BITS - 1)) begin
            idx_d = '0;
            state_d = rx_s_q ? S_IDLE : S_WAIT;
            // a held word that is not being taken this cycle wins over the new one
            if (!valid_q || i_Rx_Ready) begin
              valid_d = 1'b1;
              data_d = shift_q;
              pe_d = perr_q;
              fe_d = ferr_q | ~rx_s_q;
              brk_d = ~(ones_q | rx_s_q);
            end else begin
              ovr_d = 1'b1;
            end
          end
        end
      end
      S_WAIT: state_d = rx_s_q ? S_IDLE : S_WAIT;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      sync_q <= 1'b1;
      rx_s_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ones_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      pe_q <= 1'b0;
      fe_q <= 1'b0;
      brk_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= i_Rx_Serial;
      rx_s_q <= sync_q;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      shift_q <= shift_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ones_q <= ones_d;
      valid_q <= valid_d;
      data_q <= data_d;
      pe_q <= pe_d;
      fe_q <= fe_d;
      brk_q <= brk_d;
      ovr_q <= ovr_d;
    end
  end
  assign o_Rx_Valid = valid_q;
  assign o_Rx_Data = data_q;
  assign o_Parity_Err = pe_q;
  assign o_Frame_Err = fe_q;
  assign o_Break = brk_q;
  assign o_Overrun = ovr_q;
  assign o_Busy = state_q != S_IDLE;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: three receiver configurations driven by a frame-level model with a scoreboard monitor
module tb_uart_rx_cfg;
  localparam int CPB = 16;
  localparam int NB [3] = '{8, 7, 8};
  localparam int PM [3] = '{2, 1, 0};
  localparam int NS [3] = '{1, 2, 1};
  typedef struct packed {logic [8:0] d; logic pe; logic fe; logic br;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] rx = 3'b111, rdy = 3'b111;
  logic [2:0] vld, pe, fe, br, ovr, busy;
  logic [7:0] d0, d2;
  logic [6:0] d1;
  exp_t q [3][$];
  exp_t mon_e;
  int checks = 0, failures = 0;
  int ovr_seen [3] = '{0, 0, 0};
  int ovr_exp [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u0 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[0]), .i_Rx_Ready(rdy[0]), .o_Rx_Valid(vld[0]),
    .o_Rx_Data(d0), .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(br[0]), .o_Overrun(ovr[0]), .o_Busy(busy[0]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u1 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[1]), .i_Rx_Ready(rdy[1]), .o_Rx_Valid(vld[1]),
    .o_Rx_Data(d1), .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(br[1]), .o_Overrun(ovr[1]), .o_Busy(busy[1]));
  uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u2 (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_Serial(rx[2]), .i_Rx_Ready(rdy[2]), .o_Rx_Valid(vld[2]),
    .o_Rx_Data(d2), .o_Parity_Err(pe[2]), .o_Frame_Err(fe[2]), .o_Break(br[2]), .o_Overrun(ovr[2]), .o_Busy(busy[2]));

  function automatic logic [8:0] dat(int u);
    return (u == 0) ? {1'b0, d0} : (u == 1) ? {2'b0, d1} : {1'b0, d2};
  endfunction

  task automatic chk(string nm, int got, int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(int u, logic b);
    rx[u] = b;
    tick(CPB);
  endtask

  // frame-level model: expected word derived from what goes on the wire
  task automatic send(int u, logic [8:0] din, logic flip, logic [1:0] stp);
    logic [8:0] d;
    logic pb;
    exp_t e;
    d = din & 9'((1 << NB[u]) - 1);
    pb = ((PM[u] == 1) ? ~^d : ^d) ^ flip;
    e.d = d;
    e.pe = (PM[u] != 0) && flip;
    e.fe = !stp[0] || (NS[u] == 2 && !stp[1]);
    e.br = (d == 0) && (PM[u] == 0 || !pb) && !stp[0] && (NS[u] == 1 || !stp[1]);
    if (rdy[u] || q[u].size() == 0) q[u].push_back(e);
    else ovr_exp[u]++;
    drive_bit(u, 1'b0);
    for (int i = 0; i < NB[u]; i++) drive_bit(u, d[i]);
    if (PM[u] != 0) drive_bit(u, pb);
    for (int i = 0; i < NS[u]; i++) drive_bit(u, stp[i]);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int u = 0; u < 3; u++) begin
        if (ovr[u]) ovr_seen[u]++;
        if (vld[u] && rdy[u]) begin
          checks++;
          if (q[u].size() == 0) begin
            failures++;
            $display("FAIL unexpected_word u%0d got=%h", u, dat(u));
          end else begin
            mon_e = q[u].pop_front();
            if ({dat(u), pe[u], fe[u], br[u]} !== mon_e) begin
              failures++;
              $display("FAIL word u%0d got d=%h pe=%b fe=%b br=%b exp d=%h pe=%b fe=%b br=%b",
                       u, dat(u), pe[u], fe[u], br[u], mon_e.d, mon_e.pe, mon_e.fe, mon_e.br);
            end
          end
        end
      end
    end
  end

  initial begin
    int u, gap;
    logic [1:0] stp;
    exp_t brk_e;
    tick(5);
    for (int k = 0; k < 3; k++)
      chk($sformatf("reset_outputs_u%0d", k), int'({vld[k], pe[k], fe[k], br[k], ovr[k], busy[k], dat(k)}), 0);
    rst = 1'b0;
    tick(5);
    send(2, 9'hA5, 1'b0, 2'b11);
    tick(20);
    chk("a5_drained", q[2].size(), 0);
    send(0, 9'h03, 1'b0, 2'b11);
    send(0, 9'h03, 1'b1, 2'b11);
    tick(20);
    chk("parity_drained", q[0].size(), 0);
    send(1, 9'h55, 1'b0, 2'b01);
    tick(2 * CPB);
    chk("wait_high_busy", busy[1], 1);
    chk("wait_high_no_word", vld[1], 0);
    rx[1] = 1'b1;
    tick(8);
    chk("wait_high_exit", busy[1], 0);
    send(1, 9'h2A, 1'b0, 2'b11);
    tick(20);
    chk("frame_drained", q[1].size(), 0);
    brk_e = '{d: 9'h0, pe: 1'b0, fe: 1'b1, br: 1'b1};
    q[0].push_back(brk_e);
    rx[0] = 1'b0;
    tick(20 * CPB);
    chk("break_busy", busy[0], 1);
    chk("break_drained", q[0].size(), 0);
    rx[0] = 1'b1;
    tick(8);
    chk("break_exit", busy[0], 0);
    rdy[2] = 1'b0;
    send(2, 9'h11, 1'b0, 2'b11);
    send(2, 9'h22, 1'b0, 2'b11);
    tick(20);
    chk("overrun_pulses", ovr_seen[2], 1);
    chk("overrun_held_valid", vld[2], 1);
    chk("overrun_held_data", int'(dat(2)), 'h11);
    rdy[2] = 1'b1;
    tick(5);
    chk("overrun_single_xfer", q[2].size(), 0);
    chk("overrun_valid_clear", vld[2], 0);
    rx[2] = 1'b0;
    tick(3);
    rx[2] = 1'b1;
    tick(2);
    chk("glitch_busy", busy[2], 1);
    tick(30);
    chk("glitch_idle", busy[2], 0);
    chk("glitch_no_word", vld[2], 0);
    for (int n = 0; n < 45; n++) begin
      u = $urandom_range(0, 2);
      stp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
      send(u, ($urandom_range(0, 7) == 0) ? 9'h0 : 9'($urandom), ($urandom_range(0, 3) == 0), stp);
      if (!stp[NS[u] - 1]) begin
        rx[u] = 1'b1;
        tick(CPB);
      end
      gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 20);
      tick(gap);
    end
    tick(20);
    rdy[2] = 1'b0;
    send(2, 9'h3C, 1'b0, 2'b11);
    tick(5);
    chk("pre_reset_held", vld[2], 1);
    rx[2] = 1'b0;
    tick(CPB);
    drive_bit(2, 1'b1);
    drive_bit(2, 1'b0);
    drive_bit(2, 1'b1);
    rst = 1'b1;
    tick(2);
    chk("midframe_reset_outputs", int'({vld[2], pe[2], fe[2], br[2], ovr[2], busy[2], dat(2)}), 0);
    q[2].delete();
    rx[2] = 1'b1;
    rdy[2] = 1'b1;
    rst = 1'b0;
    tick(12 * CPB);
    chk("midframe_no_word", vld[2], 0);
    chk("midframe_idle", busy[2], 0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("final_queue_u%0d", k), q[k].size(), 0);
      chk($sformatf("final_overruns_u%0d", k), ovr_seen[k], ovr_exp[k]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
